// File: rtl/semaforo_pkg.sv
// Shared types and defaults for the traffic-light sensor front end.
package semaforo_pkg;

    localparam int COUNT_W             = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES     = 8;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        ACTIVE,
        HOLD
    } sensor_state_e;

    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] v
    );
        return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sensor_channel.sv
// One car-sensor lane: synchronizer, debounce/hold FSM, arrival counter.
module sensor_channel
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               raw,
    input  logic               clear_counts,
    output logic               present,
    output logic [COUNT_W-1:0] arrivals
);

    localparam logic [COUNT_W-1:0] DEB_LAST  = COUNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] HOLD_LAST = COUNT_W'(HOLD_CYCLES - 1);

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    sensor_state_e      state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               present_q, present_d;
    logic [COUNT_W-1:0] arrivals_q, arrivals_d;
    logic               confirm;

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        arrivals_d = arrivals_q;
        confirm    = 1'b0;

        // cnt_q holds the samples already seen in the current run
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = CONFIRM;
                    cnt_d   = COUNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            CONFIRM: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    confirm = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                if (!sync2_q) begin
                    state_d = HOLD;
                    cnt_d   = COUNT_W'(1);
                end
            end
            HOLD: begin
                if (sync2_q) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // a clear landing on an arrival edge still leaves zero
        if (clear_counts) begin
            arrivals_d = '0;
        end else if (confirm) begin
            arrivals_d = sat_inc(arrivals_q);
        end

        present_d = (state_d == ACTIVE) || (state_d == HOLD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            present_q  <= 1'b0;
            arrivals_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            present_q  <= present_d;
            arrivals_q <= arrivals_d;
        end
    end

    assign present  = present_q;
    assign arrivals = arrivals_q;

endmodule

// File: rtl/traffic_sensor_filter.sv
// Filters the two street sensors into clean TA/TB presence flags.
module traffic_sensor_filter
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sensor_a,
    input  logic               sensor_b,
    input  logic               clear_counts,
    output logic               TA,
    output logic               TB,
    output logic [COUNT_W-1:0] arrivals_a,
    output logic [COUNT_W-1:0] arrivals_b
);

    sensor_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan_a (
        .clock       (clock),
        .reset       (reset),
        .raw         (sensor_a),
        .clear_counts(clear_counts),
        .present     (TA),
        .arrivals    (arrivals_a)
    );

    sensor_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan_b (
        .clock       (clock),
        .reset       (reset),
        .raw         (sensor_b),
        .clear_counts(clear_counts),
        .present     (TB),
        .arrivals    (arrivals_b)
    );

endmodule

// File: tb/tb_traffic_sensor_filter.sv
// Scoreboard bench for traffic_sensor_filter with a run-length reference model.
module tb_traffic_sensor_filter;

    localparam int D = 4;
    localparam int H = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       sensor_a;
    logic       sensor_b;
    logic       clear_counts;
    logic       TA;
    logic       TB;
    logic [7:0] arrivals_a;
    logic [7:0] arrivals_b;

    always #5 clock = ~clock;

    traffic_sensor_filter #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sensor_a    (sensor_a),
        .sensor_b    (sensor_b),
        .clear_counts(clear_counts),
        .TA          (TA),
        .TB          (TB),
        .arrivals_a  (arrivals_a),
        .arrivals_b  (arrivals_b)
    );

    typedef struct {
        bit ta;
        bit tb;
        int arr_a;
        int arr_b;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference: sync delay line plus consecutive-run lengths per channel
    bit m_s1[2];
    bit m_s2[2];
    bit m_flag[2];
    int hi_run[2];
    int lo_run[2];
    int m_arr[2];

    task automatic model_edge(input bit a, input bit b, input bit clr, input bit rst);
        bit raw[2];
        bit smp;
        raw[0] = a;
        raw[1] = b;
        for (int ch = 0; ch < 2; ch++) begin
            if (rst) begin
                m_s1[ch] = 0; m_s2[ch] = 0; m_flag[ch] = 0;
                hi_run[ch] = 0; lo_run[ch] = 0; m_arr[ch] = 0;
            end else begin
                smp = m_s2[ch];
                if (!m_flag[ch]) begin
                    hi_run[ch] = smp ? hi_run[ch] + 1 : 0;
                    if (hi_run[ch] == D) begin
                        m_flag[ch] = 1;
                        lo_run[ch] = 0;
                        if (m_arr[ch] < 255) m_arr[ch]++;
                    end
                end else begin
                    lo_run[ch] = smp ? 0 : lo_run[ch] + 1;
                    if (lo_run[ch] == H) begin
                        m_flag[ch] = 0;
                        hi_run[ch] = 0;
                    end
                end
                if (clr) m_arr[ch] = 0;
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = raw[ch];
            end
        end
    endtask

    task automatic step(input bit a, input bit b, input bit clr, input bit rst);
        exp_t e;
        @(negedge clock);
        sensor_a     = a;
        sensor_b     = b;
        clear_counts = clr;
        reset        = rst;
        model_edge(a, b, clr, rst);
        e.ta    = m_flag[0];
        e.tb    = m_flag[1];
        e.arr_a = m_arr[0];
        e.arr_b = m_arr[1];
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    exp_t mon_e;
    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("TA", int'(TA), int'(mon_e.ta));
            chk("TB", int'(TB), int'(mon_e.tb));
            chk("arrivals_a", int'(arrivals_a), mon_e.arr_a);
            chk("arrivals_b", int'(arrivals_b), mon_e.arr_b);
        end
    end

    initial begin
        reset        = 1'b1;
        sensor_a     = 1'b0;
        sensor_b     = 1'b0;
        clear_counts = 1'b0;

        repeat (3) step(0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0);

        // street B held high: TB rises on the sixth edge
        repeat (12) step(0, 1, 0, 0);
        repeat (12) step(0, 0, 0, 0);

        // short then long pulse on A
        repeat (3) step(1, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0);

        // dropout shorter than hold, then drop for good
        repeat (6) step(0, 0, 0, 0);
        repeat (6) step(1, 0, 0, 0);
        repeat (12) step(0, 0, 0, 0);

        // both streets together
        repeat (8) step(1, 1, 0, 0);
        repeat (12) step(0, 0, 0, 0);

        // saturate the A counter
        for (int n = 0; n < 300; n++) begin
            repeat (5) step(1, 0, 0, 0);
            repeat (10) step(0, 0, 0, 0);
        end

        // clear on the very edge of an arrival
        repeat (5) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0);

        // reset while in HOLD
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (8) step(1, 0, 0, 0);

        // randomized bursts with occasional clear and reset
        for (int n = 0; n < 120; n++) begin
            int len;
            bit ra, rb;
            len = $urandom_range(1, 12);
            ra  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                step(ra, rb, $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
            end
        end

        repeat (3) step(0, 0, 0, 0);
        @(posedge clock);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_filter.md
TRAFFIC_SENSOR_FILTER -- requirements
Module: traffic_sensor_filter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive synchronized-high samples needed to assert presence; legal range 2..15.
REQ-002 Parameter HOLD_CYCLES, default 8, SHALL set the consecutive synchronized-low samples needed to deassert presence; legal range 2..255.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sensor_a  in  1  raw, asynchronous, possibly bouncing car sensor for street A.
REQ-007 sensor_b  in  1  raw, asynchronous, possibly bouncing car sensor for street B.
REQ-008 clear_counts  in  1  synchronous clear of both arrival counters.
REQ-009 TA  out  1  filtered traffic-present flag for street A; feeds the traffic-light FSM input TA.
REQ-010 TB  out  1  filtered traffic-present flag for street B; feeds the traffic-light FSM input TB.
REQ-011 arrivals_a  out  8  saturating count of confirmed street-A arrivals.
REQ-012 arrivals_b  out  8  saturating count of confirmed street-B arrivals.

Function
REQ-013 Each sensor SHALL pass through a 2-flop synchronizer; only the second flop output (sync) SHALL be used downstream.
REQ-014 Each channel SHALL run an independent FSM with states IDLE, CONFIRM, ACTIVE, HOLD; the channels SHALL share no state.
REQ-015 IDLE: flag 0; sync=1 -> CONFIRM, with the current sample counted as 1.
REQ-016 CONFIRM: flag 0; sync=0 -> IDLE, counter cleared; sync=1 increments; the DEBOUNCE_CYCLES-th consecutive high sample -> ACTIVE.
REQ-017 ACTIVE: flag 1; sync=0 -> HOLD, with the current sample counted as 1; sync=1 stays.
REQ-018 HOLD: flag 1; sync=1 -> ACTIVE, counter cleared; the HOLD_CYCLES-th consecutive low sample -> IDLE.
REQ-019 TA/TB SHALL be registered, decoded from the state (ACTIVE or HOLD), with no combinational path from sensor inputs.
REQ-020 Rise latency: with raw held high, the flag SHALL go 1 on rising edge 2+DEBOUNCE_CYCLES, counting the first edge sampling raw=1 as edge 1.
REQ-021 Fall latency: with raw held low, the flag SHALL go 0 on rising edge 2+HOLD_CYCLES, counting the first edge sampling raw=0 as edge 1.
REQ-022 A high pulse shorter than DEBOUNCE_CYCLES sync samples SHALL never assert the flag.
REQ-023 A dropout shorter than HOLD_CYCLES sync samples SHALL never deassert the flag.
REQ-024 Arrival counter: +1 on each CONFIRM->ACTIVE transition only; HOLD->ACTIVE SHALL NOT count.
REQ-025 Counters SHALL saturate at 255 with no wrap.
REQ-026 clear_counts SHALL zero both counters on the next edge; clear SHALL win over a simultaneous increment.
REQ-027 Both flags may be 1 simultaneously; the block SHALL NOT arbitrate between them.

Reset
REQ-028 reset=1 SHALL, on the next rising edge, set synchronizers to 0, FSMs to IDLE, counters to 0, and TA=TB=0.
REQ-029 Reset mid-operation in any state SHALL abandon the partial count; after release, detection SHALL restart with full rise latency.
REQ-030 reset SHALL take priority over clear_counts and all sensor activity.

Structure
REQ-031 Shared package semaforo_pkg SHALL hold: the sensor state enum (IDLE, CONFIRM, ACTIVE, HOLD), the default DEBOUNCE_CYCLES/HOLD_CYCLES, and the count width constant (8).
REQ-032 One sub-module, sensor_channel (synchronizer + FSM + counters + arrival counter), SHALL be instantiated twice; the top level is wiring only.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, period 10 ns)
REQ-033 Reset 3 cycles, sensors 0 -> TA=TB=0, arrivals_a=arrivals_b=0 for the whole reset and the 10 cycles after it.
REQ-034 sensor_b held 1 from edge k -> TB=1 exactly on edge k+5 (edge 6 counting k as 1), arrivals_b=1, TA stays 0.
REQ-035 sensor_a pulsed 1 for 3 cycles -> TA never 1, arrivals_a=0; then a 5-cycle pulse -> TA=1 and arrivals_a=1.
REQ-036 TA active, sensor_a dropped for 6 cycles then restored -> TA stays 1, arrivals_a unchanged; then dropped for good -> TA=0 on edge 10 after the drop.
REQ-037 Both sensors 1 simultaneously -> TA and TB both 1 on the same edge; 300 confirmed arrivals on A -> arrivals_a=255.
REQ-038 clear_counts asserted on the same edge as a confirmed arrival -> arrivals_a=0; reset asserted while in HOLD -> TA=0 on the next edge.
